or1200_aes_insn_ctrl: RTL and testbench
=======================================

// Module: or1200_aes_insn_ctrl
// PURPOSE
//  Upstream sequencer for the AES instruction wrapper, in the CPU clock domain.
//  Collects 32-bit key/plaintext words from the core, drives ld/key/text_in
//  into the wrapper and waits for its single-cycle done pulse.
//  Captures the 128-bit ciphertext into a result register for word readback.
//  Flags an error if done never arrives.
// PARAMETERS
//  LD_HOLD      2    clk cycles aes_ld is held high per operation (>=1)
//  TIMEOUT      64   clk cycles allowed in WAIT before err (>=2)
//  TO_WIDTH     7    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk          in   1    CPU clock; sole clock of this block
//  rst          in   1    async reset, active low
//  wr_en        in   1    write strobe for operand words
//  wr_addr      in   3    0-3 key words, 4-7 text words; word 0/4 = bits [127:96]
//  wr_data      in   32   operand word
//  start        in   1    launch encryption, sampled in IDLE only
//  rd_addr      in   2    result word select; 0 = bits [127:96]
//  rd_data      out  32   combinational mux of result register
//  busy         out  1    high in LOAD/WAIT
//  res_valid    out  1    result register holds ciphertext of last op
//  err          out  1    last op timed out
//  aes_ld       out  1    to wrapper ld
//  aes_done     in   1    from wrapper done (1-cycle pulse, clk domain)
//  aes_key      out  128  key register, direct drive
//  aes_text_in  out  128  text register, direct drive
//  aes_text_buf in   128  wrapper ciphertext, valid when aes_done is high
// BEHAVIOUR
//  Reset (async, rst==0):
//   - state=IDLE; aes_ld=0; busy=0; res_valid=0; err=0.
//   - key, text, result and counters all cleared to 0.
//  Operand writes:
//   - Accepted only when busy==0; ignored in LOAD/WAIT, so key/text stay stable.
//  FSM:
//   - IDLE: start -> LOAD on next edge; res_valid<=0; err<=0; hold cnt<=LD_HOLD-1.
//     A write in the same cycle as start is applied, and the op uses the new value.
//   - LOAD: aes_ld=1 (registered). The first ld-high cycle is the one after the
//     start edge. Stays LD_HOLD cycles, then -> WAIT with aes_ld<=0 and timeout
//     counter <= 0. The wrapper detects the ld edge; a high ld also re-arms its
//     done logic.
//   - WAIT: aes_ld=0; counter increments each cycle.
//     - aes_done==1: result<=aes_text_buf, res_valid<=1, busy<=0, -> IDLE (same edge).
//     - counter==TIMEOUT-1 with no done: err<=1, res_valid stays 0, -> IDLE.
//     - done and timeout in the same cycle: done wins, err stays 0.
//  Spurious inputs:
//   - aes_done outside WAIT is ignored; result is not updated.
//   - start while busy is ignored; it is not queued.
//  Outputs and reset:
//   - busy is decoded from state: high in LOAD and WAIT.
//   - rd_data is valid whenever res_valid==1; stale or zero otherwise.
//   - Reset mid-operation aborts immediately: aes_ld drops and the wrapper's
//     late done is ignored after reset (state is IDLE).
//  Latency: start at edge 0 -> aes_ld high over edges 1..LD_HOLD
//   -> res_valid at the edge sampling aes_done.
// TESTING
//  1. FIPS-197 C.1 vector: key 000102..0f, text 00112233..ff, start; model done
//     after 12 cycles -> aes_ld high 2 cycles; res_valid=1; rd_data words
//     69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
//  2. No done, TIMEOUT=64 -> err=1 and busy=0 exactly 64 cycles after entering
//     WAIT; res_valid=0.
//  3. Writes to addr 0 and 5 during WAIT -> aes_key/aes_text_in unchanged; start
//     pulses while busy give no second aes_ld rise.
//  4. wr_addr=4 with data A5A5A5A5 in the same cycle as start
//     -> aes_text_in[127:96]=A5A5A5A5 while aes_ld is high.
//  5. Done on the counter's final WAIT cycle -> res_valid=1, err=0. Done injected
//     in IDLE -> result unchanged.
//  6. rst low during WAIT -> all outputs 0 asynchronously. Following done is
//     ignored; a new start works normally.

Source files
------------

// File: rtl/or1200_aes_insn_ctrl.sv
// Upstream sequencer for the AES instruction wrapper: gathers key/text words,
// pulses ld into the wrapper, waits for done and latches the ciphertext.
module or1200_aes_insn_ctrl #(
  parameter int unsigned LD_HOLD  = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned TO_WIDTH = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic [1:0]    rd_addr,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          res_valid,
  output logic          err,
  output logic          aes_ld,
  input  logic          aes_done,
  output logic [127:0]  aes_key,
  output logic [127:0]  aes_text_in,
  input  logic [127:0]  aes_text_buf
);

  localparam int unsigned HOLD_W = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ld_q, ld_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic                  res_valid_q, res_valid_d;
  logic                  err_q, err_d;
  logic                  res_cap;
  logic                  wr_accept;
  logic [127:0]          key_q, text_q, result_q;

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ld_q        <= 1'b0;
      hold_q      <= '0;
      to_q        <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; done has priority over the timeout in WAIT
  always_comb begin
    state_d     = state_q;
    ld_d        = 1'b0;
    hold_d      = hold_q;
    to_d        = to_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    res_cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          ld_d        = 1'b1;
          hold_d      = HOLD_W'(LD_HOLD - 1);
          res_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hold_q == '0) begin
          state_d = ST_WAIT;
          ld_d    = 1'b0;
          to_d    = '0;
        end else begin
          ld_d   = 1'b1;
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        if (aes_done) begin
          res_cap     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (to_q == TO_WIDTH'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_accept = wr_en && (state_q == ST_IDLE);

  // Operand registers; frozen while an operation is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q  <= '0;
      text_q <= '0;
    end else if (wr_accept) begin
      case (wr_addr)
        3'd0: key_q[127:96]  <= wr_data;
        3'd1: key_q[95:64]   <= wr_data;
        3'd2: key_q[63:32]   <= wr_data;
        3'd3: key_q[31:0]    <= wr_data;
        3'd4: text_q[127:96] <= wr_data;
        3'd5: text_q[95:64]  <= wr_data;
        3'd6: text_q[63:32]  <= wr_data;
        default: text_q[31:0] <= wr_data;
      endcase
    end
  end

  // Result register, loaded only on done while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
    end else if (res_cap) begin
      result_q <= aes_text_buf;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = result_q[127:96];
      2'd1:    rd_data = result_q[95:64];
      2'd2:    rd_data = result_q[63:32];
      default: rd_data = result_q[31:0];
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = res_valid_q;
  assign err         = err_q;
  assign aes_ld      = ld_q;
  assign aes_key     = key_q;
  assign aes_text_in = text_q;

endmodule

// File: tb/tb_or1200_aes_insn_ctrl.sv
// Directed bench for or1200_aes_insn_ctrl with hand-computed expectations.
module tb_or1200_aes_insn_ctrl;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic [1:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          busy;
  logic          res_valid;
  logic          err;
  logic          aes_ld;
  logic          aes_done;
  logic [127:0]  aes_key;
  logic [127:0]  aes_text_in;
  logic [127:0]  aes_text_buf;

  int n_vec;
  int n_err;
  int ld_rises;
  logic ld_prev;

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TEXT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  or1200_aes_insn_ctrl #(
    .LD_HOLD  (2),
    .TIMEOUT  (64),
    .TO_WIDTH (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .res_valid    (res_valid),
    .err          (err),
    .aes_ld       (aes_ld),
    .aes_done     (aes_done),
    .aes_key      (aes_key),
    .aes_text_in  (aes_text_in),
    .aes_text_buf (aes_text_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_prev <= 1'b0;
    end else begin
      ld_prev <= aes_ld;
      if (aes_ld && !ld_prev) ld_rises <= ld_rises + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic load_c1();
    for (int i = 0; i < 4; i++) begin
      logic [127:0] k, t;
      k = KEY_C1 << (32 * i);
      t = TEXT_C1 << (32 * i);
      wr(3'(i), k[127:96]);
      wr(3'(i + 4), t[127:96]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_done(input logic [127:0] ct);
    aes_done = 1'b1; aes_text_buf = ct;
    tick(1);
    aes_done = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [127:0] exp);
    for (int i = 0; i < 4; i++) begin
      logic [127:0] e;
      e = exp << (32 * i);
      rd_addr = 2'(i);
      #1;
      chk(tag, 128'(rd_data), 128'(e[127:96]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rises0;
    n_vec = 0; n_err = 0; ld_rises = 0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    rd_addr = '0; aes_done = 1'b0; aes_text_buf = '0;
    tick(2);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ld", 128'(aes_ld), 128'(0));
    chk("rst_flags", {126'd0, res_valid, err}, 128'd0);
    chk("rst_rd", 128'(rd_data), 128'd0);
    rst = 1'b1;
    tick(1);

    // FIPS-197 C.1 with busy-time writes and starts
    load_c1();
    chk("c1_key", aes_key, KEY_C1);
    chk("c1_text", aes_text_in, TEXT_C1);
    rises0 = ld_rises;
    pulse_start();
    chk("c1_ld1", {126'd0, aes_ld, busy}, 128'd3);
    tick(1);
    chk("c1_ld2", 128'(aes_ld), 128'(1));
    tick(1);
    chk("c1_wait", {126'd0, aes_ld, busy}, 128'd1);
    wr(3'd0, 32'hdeadbeef);
    wr(3'd5, 32'hcafef00d);
    pulse_start();
    tick(1);
    pulse_start();
    chk("busy_key", aes_key, KEY_C1);
    chk("busy_text", aes_text_in, TEXT_C1);
    tick(7);
    pulse_done(CT_C1);
    chk("c1_flags", {125'd0, res_valid, err, busy}, 128'd4);
    chk("c1_rises", 128'(ld_rises - rises0), 128'd1);
    chk_result("c1_rd", CT_C1);

    // Timeout: 64 cycles in WAIT without done
    pulse_start();
    chk("to_clr", {126'd0, res_valid, err}, 128'd0);
    tick(2);
    chk("to_wait", {126'd0, aes_ld, busy}, 128'd1);
    tick(63);
    chk("to_pre", {126'd0, busy, err}, 128'd2);
    tick(1);
    chk("to_post", {125'd0, busy, err, res_valid}, 128'd2);

    // Write in the same cycle as start is used by that op
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hA5A5A5A5; start = 1'b1;
    tick(1);
    wr_en = 1'b0; start = 1'b0;
    chk("same_ld", 128'(aes_ld), 128'(1));
    chk("same_text", 128'(aes_text_in[127:96]), 128'h A5A5A5A5);
    chk("same_err", 128'(err), 128'(0));
    tick(2);
    tick(63);
    pulse_done(128'h0123456789abcdeffedcba9876543210);
    chk("last_flags", {125'd0, res_valid, err, busy}, 128'd4);
    chk_result("last_rd", 128'h0123456789abcdeffedcba9876543210);
    pulse_done(128'hffffffffffffffffffffffffffffffff);
    chk("idle_done_v", 128'(res_valid), 128'(1));
    chk_result("idle_done_rd", 128'h0123456789abcdeffedcba9876543210);

    // Async reset in WAIT, late done ignored, recovery
    pulse_start();
    tick(5);
    #2 rst = 1'b0;
    #1;
    rd_addr = 2'd0;
    #1;
    chk("arst_ctl", {124'd0, aes_ld, busy, res_valid, err}, 128'd0);
    chk("arst_key", aes_key, 128'd0);
    chk("arst_text", aes_text_in, 128'd0);
    chk("arst_rd", 128'(rd_data), 128'd0);
    tick(1);
    rst = 1'b1;
    pulse_done(CT_C1);
    chk("late_done", {125'd0, res_valid, busy, err}, 128'd0);
    chk("late_rd", 128'(rd_data), 128'd0);
    load_c1();
    pulse_start();
    chk("rec_ld", 128'(aes_ld), 128'(1));
    tick(5);
    pulse_done(CT_C1);
    chk("rec_flags", {125'd0, res_valid, err, busy}, 128'd4);
    chk_result("rec_rd", CT_C1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
